// File: rtl/cfg_chain_loader.sv
// Serial configuration chain driver: collects a frame over a byte stream, shifts it
// into a user chain via shift_clk/shift_dta, and optionally re-shifts it while checking the tail.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | accepting frame bytes, in_ready high
// LOAD   | shifting the frame into the chain, buffer MSB first
// VERIFY | re-shifting the frame while comparing the chain tail
// DONE   | one-cycle done pulse, then back to IDLE
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int HALF      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       verify_en,
    input  logic       chain_out,
    output logic       shift_clk,
    output logic       shift_dta,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] mismatch_cnt
);

    localparam int NBYTES   = CHAIN_LEN / 8;
    localparam int BCW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BW       = $clog2(CHAIN_LEN);
    localparam int PW       = $clog2(2 * HALF);
    localparam bit ONE_BYTE = (NBYTES == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t               state;
    logic [CHAIN_LEN-1:0] frame_buf;
    logic [BCW-1:0]       byte_cnt;
    logic [PW-1:0]        phase;
    logic [BW-1:0]        bit_idx;
    logic                 verify_lat;
    logic                 sync1;
    logic                 sync2;

    logic [BW-1:0]        wr_base;
    logic [BW-1:0]        bit_next;
    logic [BW-1:0]        tx_idx;
    logic                 first_bit;

    assign wr_base   = BW'(CHAIN_LEN - 1 - 8 * int'(byte_cnt));
    assign bit_next  = bit_idx + BW'(1);
    assign tx_idx    = BW'(CHAIN_LEN - 1) - bit_next;
    // A one-byte chain has its top bit arriving in the same cycle the load starts.
    assign first_bit = ONE_BYTE ? in_data[7] : frame_buf[CHAIN_LEN-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            frame_buf    <= '0;
            byte_cnt     <= '0;
            phase        <= '0;
            bit_idx      <= '0;
            verify_lat   <= 1'b0;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            shift_clk    <= 1'b0;
            shift_dta    <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            sync1 <= chain_out;
            sync2 <= sync1;
            done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        frame_buf[wr_base -: 8] <= in_data;
                        if (byte_cnt == '0) begin
                            mismatch_cnt <= '0;
                            error        <= 1'b0;
                        end
                        if (byte_cnt == BCW'(NBYTES - 1)) begin
                            byte_cnt   <= '0;
                            verify_lat <= verify_en;
                            state      <= S_LOAD;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                            phase      <= '0;
                            bit_idx    <= '0;
                            shift_clk  <= 1'b0;
                            shift_dta  <= first_bit;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end

                S_LOAD, S_VERIFY: begin
                    // Tail is sampled on the last low-phase cycle, well after the synchronizer settles.
                    if (state == S_VERIFY && phase == PW'(HALF - 1) && sync2 != shift_dta
                        && mismatch_cnt != 8'hFF) begin
                        mismatch_cnt <= mismatch_cnt + 8'd1;
                        error        <= 1'b1;
                    end

                    if (phase == PW'(2 * HALF - 1)) begin
                        phase     <= '0;
                        shift_clk <= 1'b0;
                        if (bit_idx == BW'(CHAIN_LEN - 1)) begin
                            bit_idx <= '0;
                            if (state == S_LOAD && verify_lat) begin
                                state     <= S_VERIFY;
                                shift_dta <= frame_buf[CHAIN_LEN-1];
                            end else begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_next;
                            shift_dta <= frame_buf[tx_idx];
                        end
                    end else begin
                        phase <= phase + PW'(1);
                        if (phase == PW'(HALF - 1))
                            shift_clk <= 1'b1;
                    end
                end

                S_DONE: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
